fetch_unit: RTL and testbench

Instruction-fetch sequencer that owns the program counter and drives the address port of instruction_memory (word-addressed, synchronous read with 1-cycle latency). It issues sequential fetches, tracks the in-flight read, and buffers returned words in a 2-entry queue. Decode consumes that queue through a valid/ready handshake. Branch redirects squash in-flight and buffered words; halt stops issue.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_queue.sv | 66 ++++++
 rtl/fetch_unit.sv | 92 +++++++++
 tb/tb_fetch_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and sizing for the instruction-fetch sequencer
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        STALL  = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    localparam int QUEUE_DEPTH = 2;
    localparam int QCOUNT_W    = $clog2(QUEUE_DEPTH + 1);

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - 2-entry instruction/pc FIFO with flush
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_instr,
    input  logic [ADDR_WIDTH-1:0] push_pc,
    input  logic                  pop,
    input  logic                  flush,
    output logic [QCOUNT_W-1:0]   count,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] head_instr,
    output logic [ADDR_WIDTH-1:0] head_pc
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] instr;
        logic [ADDR_WIDTH-1:0] pc;
    } fetch_entry_t;

    fetch_entry_t slots [QUEUE_DEPTH];
    logic [0:0]   rd_ptr;
    logic [0:0]   wr_ptr;
    logic         full;
    logic         do_push;
    logic         do_pop;

    assign empty   = (count == '0);
    assign full    = (count == QCOUNT_W'(QUEUE_DEPTH));
    assign do_pop  = pop & ~empty;
    // When full, a push is only legal because the simultaneous pop frees the head slot
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                slots[wr_ptr] <= '{instr: push_instr, pc: push_pc};
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + QCOUNT_W'(do_push) - QCOUNT_W'(do_pop);
        end
    end

    assign head_instr = slots[rd_ptr].instr;
    assign head_pc    = slots[rd_ptr].pc;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner, imem issue sequencer and decode-side handshake
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_instruct,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  halt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic                  busy
);

    fetch_state_e          state;
    fetch_state_e          state_next;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] inflight_pc;
    logic                  inflight;
    logic [QCOUNT_W-1:0]   count;
    logic                  empty;
    logic                  pop;
    logic                  push;
    logic                  issue;
    logic [QCOUNT_W:0]     occupancy;

    assign imem_addr = pc;
    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;
    // A redirect squashes the word returning at the same edge
    assign push      = inflight & ~redirect_valid;
    assign busy      = inflight | ~empty;

    // Slots already committed once this edge settles, excluding the fetch being decided
    assign occupancy = (QCOUNT_W+1)'(count) + (QCOUNT_W+1)'(inflight) - (QCOUNT_W+1)'(pop);
    assign issue     = (state == FETCH) & ~halt & ~redirect_valid
                     & (occupancy < (QCOUNT_W+1)'(QUEUE_DEPTH));

    always_comb begin
        state_next = FETCH;
        if (halt) begin
            state_next = HALTED;
        end else if (!redirect_valid && count == QCOUNT_W'(QUEUE_DEPTH) && !pop) begin
            state_next = STALL;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= RESET_PC;
        end else begin
            state    <= state_next;
            inflight <= issue;
            if (issue) begin
                inflight_pc <= pc;
                pc          <= pc + ADDR_WIDTH'(1);
            end
            if (redirect_valid) begin
                pc <= redirect_pc;
            end
        end
    end

    fetch_queue #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_instr (imem_instruct),
        .push_pc    (inflight_pc),
        .pop        (pop),
        .flush      (redirect_valid),
        .count      (count),
        .empty      (empty),
        .head_instr (out_instr),
        .head_pc    (out_pc)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] imem_addr;
    logic [15:0] imem_instruct = '0;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [15:0] out_pc;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] got_pc[$];

    fetch_unit #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .RESET_PC(16'h0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_instruct  (imem_instruct),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return 16'hA000 + a;
    endfunction

    always @(posedge clk) imem_instruct <= mem_word(imem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Record every accepted handshake; a redirect at the same edge cancels the pop
    always @(posedge clk) begin
        if (rst_n && !redirect_valid && out_valid && out_ready) begin
            got_pc.push_back(out_pc);
            check("instr_matches_pc", 32'(out_instr), 32'(mem_word(out_pc)));
        end
    end

    always @(negedge clk) begin
        assert (dut.u_queue.count <= 2) else $error("queue overflow");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        halt = 1'b0;
        step();
        step();
        got_pc.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_got(input int n, input string tag);
        int k = 0;
        while (got_pc.size() < n && k < 50) begin
            step();
            k++;
        end
        check({tag, "_count"}, 32'(got_pc.size()), 32'(n));
    endtask

    function automatic logic [15:0] got_at(input int i);
        return (i < got_pc.size()) ? got_pc[i] : 16'hDEAD;
    endfunction

    initial begin
        redirect_pc = '0;
        out_ready = 1'b1;

        // Reset release and streaming
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        halt = 1'b0;
        step(); step(); step();
        check("rst_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_addr", 32'(imem_addr), 0);
        check("rst_pc", 32'(out_pc), 0);
        check("rst_instr", 32'(out_instr), 0);
        rst_n = 1'b1;
        step();
        check("s_addr1", 32'(imem_addr), 1);
        check("s_valid_early", 32'(out_valid), 0);
        step();
        check("s_addr2", 32'(imem_addr), 2);
        check("s_valid", 32'(out_valid), 1);
        check("s_pc0", 32'(out_pc), 0);
        check("s_instr0", 32'(out_instr), 32'h0000A000);
        step();
        check("s_addr3", 32'(imem_addr), 3);
        check("s_pc1", 32'(out_pc), 1);
        step();
        check("s_pc2", 32'(out_pc), 2);
        check("s_instr2", 32'(out_instr), 32'h0000A002);
        step();
        check("s_pc3", 32'(out_pc), 3);

        // Backpressure fills the queue and stalls issue
        out_ready = 1'b0;
        do_reset();
        repeat (6) step();
        check("bp_addr", 32'(imem_addr), 2);
        check("bp_count", 32'(dut.u_queue.count), 2);
        check("bp_state", 32'(dut.state), 32'(STALL));
        check("bp_head", 32'(out_pc), 0);
        out_ready = 1'b1;
        wait_got(3, "bp");
        check("bp_got0", 32'(got_at(0)), 0);
        check("bp_got1", 32'(got_at(1)), 1);
        check("bp_got2", 32'(got_at(2)), 2);

        // Redirect mid-stream squashes queued and in-flight words
        do_reset();
        repeat (6) step();
        redirect_valid = 1'b1;
        redirect_pc = 16'h0040;
        step();
        redirect_valid = 1'b0;
        check("rd_valid1", 32'(out_valid), 0);
        check("rd_addr1", 32'(imem_addr), 32'h40);
        step();
        check("rd_valid2", 32'(out_valid), 0);
        check("rd_addr2", 32'(imem_addr), 32'h41);
        step();
        check("rd_valid3", 32'(out_valid), 1);
        check("rd_head", 32'(out_pc), 32'h40);
        wait_got(6, "rd");
        check("rd_got3", 32'(got_at(3)), 3);
        check("rd_got4", 32'(got_at(4)), 32'h40);
        check("rd_got5", 32'(got_at(5)), 32'h41);

        // Halt for four cycles mid-stream
        do_reset();
        repeat (4) step();
        halt = 1'b1;
        step();
        check("h_addr0", 32'(imem_addr), 4);
        check("h_state", 32'(dut.state), 32'(HALTED));
        check("h_inflight_landed", 32'(out_pc), 3);
        check("h_busy0", 32'(busy), 1);
        step();
        check("h_busy1", 32'(busy), 0);
        check("h_valid1", 32'(out_valid), 0);
        step(); step();
        check("h_addr3", 32'(imem_addr), 4);
        halt = 1'b0;
        step();
        check("h_addr_resume", 32'(imem_addr), 4);
        wait_got(5, "h");
        check("h_got3", 32'(got_at(3)), 3);
        check("h_got4", 32'(got_at(4)), 4);

        // Redirect near the top of the address space wraps
        do_reset();
        repeat (3) step();
        redirect_valid = 1'b1;
        redirect_pc = 16'hFFFE;
        step();
        redirect_valid = 1'b0;
        got_pc.delete();
        wait_got(4, "wrap");
        check("wrap0", 32'(got_at(0)), 32'hFFFE);
        check("wrap1", 32'(got_at(1)), 32'hFFFF);
        check("wrap2", 32'(got_at(2)), 32'h0000);
        check("wrap3", 32'(got_at(3)), 32'h0001);

        // Reset with a full queue beats a simultaneous redirect
        out_ready = 1'b0;
        do_reset();
        repeat (6) step();
        rst_n = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 16'h0123;
        step();
        check("mr_valid", 32'(out_valid), 0);
        check("mr_busy", 32'(busy), 0);
        check("mr_addr", 32'(imem_addr), 0);
        rst_n = 1'b1;
        redirect_valid = 1'b0;
        out_ready = 1'b1;
        got_pc.delete();
        step();
        check("mr_valid_after", 32'(out_valid), 0);
        wait_got(1, "mr");
        check("mr_first", 32'(got_at(0)), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
